// File: rtl/retire_pkg.sv
// Shared types for the retirement monitor: trace record, FSM states, widths.
// No logic of its own; latency n/a.
// Backpressure n/a; consumed by the FIFO and the monitor top.
package retire_pkg;

    localparam int XLEN   = 32;
    localparam int DROP_W = 16;

    // One retired instruction as seen by the trace writer.
    typedef struct packed {
        logic [XLEN-1:0] seq;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            rdv;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } retire_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mon_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/retire_monitor_if.sv
// Retirement input bundle plus the outgoing trace record stream.
// Pure wiring; no latency.
// out_valid/out_ready handshake; the retire side has no backpressure.
interface retire_monitor_if;
    import retire_pkg::*;

    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;
    logic [XLEN-1:0] ret_inst;
    logic            ret_rdv;
    logic [4:0]      ret_rd;
    logic [XLEN-1:0] ret_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_seq;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_data;
    logic            out_rdv;
    logic [4:0]      out_rd;

    // CPU/bench side: produces retirements, consumes records.
    modport master (
        output ret_valid, ret_pc, ret_inst, ret_rdv, ret_rd, ret_data,
        output out_ready,
        input  out_valid, out_seq, out_pc, out_inst, out_data, out_rdv, out_rd
    );

    // Monitor side.
    modport slave (
        input  ret_valid, ret_pc, ret_inst, ret_rdv, ret_rd, ret_data,
        input  out_ready,
        output out_valid, out_seq, out_pc, out_inst, out_data, out_rdv, out_rd
    );

endinterface

// File: rtl/retire_fifo.sv
// Generic synchronous FIFO with a registered head word.
// Push at edge N is at dout after edge N; pops give back-to-back words.
// Push while full is refused unless a pop happens on the same edge.
module retire_fifo #(
    parameter int  DEPTH = 8,
    parameter type rec_t = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  rec_t din,
    input  logic pop,
    output rec_t dout,
    output logic full,
    output logic empty
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);

    rec_t          mem [DEPTH];
    rec_t          head_q;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_next;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_next_idx;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign rd_next     = do_pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign wr_idx      = wr_ptr[AW-1:0];
    assign rd_next_idx = rd_next[AW-1:0];
    assign dout        = head_q;

    // Storage, pointers and the head register, which takes the word written
    // this edge when it lands in the slot that becomes the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_idx] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_next;
            head_q <= (do_push && (rd_next_idx == wr_idx)) ? din : mem[rd_next_idx];
        end
    end

endmodule

// File: rtl/retire_monitor.sv
// Queues retired instructions as sequenced trace records; ends on pass/fail PC.
// Retirement to out_valid is one cycle; one record per cycle when drained.
// Stalled stream holds the record; full queue drops (counted, seq gaps).
// Optional RETIRE_MON_WATCHDOG_EN adds an idle-cycle timeout that fails the run.
module retire_monitor
    import retire_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    retire_monitor_if.slave   rif,
    input  logic [XLEN-1:0]   pass_pc,
    input  logic [XLEN-1:0]   fail_pc,
    output logic              done,
    output logic              pass,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    mon_state_t      state_q;
    mon_state_t      state_d;
    logic            verdict_q;
    logic            verdict_d;
    logic [XLEN-1:0] seq_q;
    logic            overflow_q;
    logic [DROP_W-1:0] drop_q;

    retire_rec_t     rec_in;
    retire_rec_t     rec_out;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            run_vld;
    logic            drop;
    logic            fail_hit;
    logic            pass_hit;
    logic            timeout_hit;

    assign run_vld  = rif.ret_valid && (state_q == RUN);
    assign pop      = rif.out_valid && rif.out_ready;
    assign drop     = run_vld && fifo_full && !pop;
    assign fail_hit = run_vld && (rif.ret_pc == fail_pc);
    assign pass_hit = run_vld && (rif.ret_pc == pass_pc);

    // Writes to x0 are architecturally discarded, so never flag them.
    assign rec_in = '{
        seq:  seq_q,
        pc:   rif.ret_pc,
        inst: rif.ret_inst,
        rdv:  rif.ret_rdv && (rif.ret_rd != 5'd0),
        rd:   rif.ret_rd,
        data: rif.ret_data
    };

    retire_fifo #(
        .DEPTH (DEPTH),
        .rec_t (retire_rec_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (run_vld),
        .din   (rec_in),
        .pop   (pop),
        .dout  (rec_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rif.out_valid = !fifo_empty && (state_q != DONE);
    assign rif.out_seq   = rec_out.seq;
    assign rif.out_pc    = rec_out.pc;
    assign rif.out_inst  = rec_out.inst;
    assign rif.out_data  = rec_out.data;
    assign rif.out_rdv   = rec_out.rdv;
    assign rif.out_rd    = rec_out.rd;

    assign done     = (state_q == DONE);
    assign pass     = done && verdict_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

`ifdef RETIRE_MON_WATCHDOG_EN
    logic [31:0] idle_q;

    // Idle counter runs only while the program is live; frozen afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else if (state_q == RUN) begin
            idle_q <= rif.ret_valid ? 32'd0 : idle_q + 32'd1;
        end
    end

    assign timeout_hit = (state_q == RUN) && (idle_q >= 32'(TIMEOUT));
`else
    wire unused_timeout = (TIMEOUT != 0);
    assign timeout_hit = 1'b0;
`endif

    // Sequence numbering and drop accounting; dropped records still consume a seq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (run_vld) begin
                seq_q <= seq_q + XLEN'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                drop_q     <= sat_inc(drop_q);
            end
        end
    end

    // FSM state and verdict registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            verdict_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
        end
    end

    // Next state: fail (or timeout) beats pass; drain fully before reporting.
    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        case (state_q)
            RUN: begin
                if (fail_hit || timeout_hit) begin
                    state_d   = DRAIN;
                    verdict_d = 1'b0;
                end else if (pass_hit) begin
                    state_d   = DRAIN;
                    verdict_d = 1'b1;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

endmodule
